// File: rtl/trgo_if.sv
// Trigger-output bundle between the timer core and the TRGO generator.
// master = the generator (drives trgo_o/trg_evt_o); slave = the consuming side.
interface trgo_if #(
    parameter int CH_PAIRS_NUM = 2
);
    logic [2:0]                  mms_i;
    logic                        ug_i;
    logic                        cen_i;
    logic                        uev_i;
    logic                        cc1_evt_i;
    logic [CH_PAIRS_NUM*2-1:0]   ocref_i;
    logic                        msm_i;
    logic [3:0]                  pw_i;
    logic                        trgo_o;
    logic                        trg_evt_o;

    modport master (
        input  mms_i, ug_i, cen_i, uev_i, cc1_evt_i, ocref_i, msm_i, pw_i,
        output trgo_o, trg_evt_o
    );

    modport slave (
        output mms_i, ug_i, cen_i, uev_i, cc1_evt_i, ocref_i, msm_i, pw_i,
        input  trgo_o, trg_evt_o
    );
endinterface

// File: rtl/trgo_generator.sv
// Master-mode TRGO generator: selects a timer event/level, optionally stretches pulses,
// optionally delays one cycle for master/slave alignment. Macro: GPT_TRGO_STRETCH_EN.
module trgo_generator #(
    parameter int CH_PAIRS_NUM = 2
) (
    input  logic   clk_i,
    input  logic   aresetn_i,
    trgo_if.master bus
);
    localparam int CH_NUM = CH_PAIRS_NUM * 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] mms_q;
    logic       mms_chg;
    logic       level_mode;
    logic       pulse_evt;
    logic       lvl_q;
    logic       pre;
    logic       dly_q;
    logic       trgo_next;
    logic       trgo;
    logic       trg_evt;

`ifdef GPT_TRGO_STRETCH_EN
    logic [3:0] cnt;
    logic [3:0] cnt_next;
`endif

    function automatic logic is_pulse(input logic [2:0] mms);
        return (mms == 3'b000) || (mms == 3'b010) || (mms == 3'b011);
    endfunction

    function automatic logic sel_pulse(input logic [2:0] mms, input logic ug,
                                       input logic uev, input logic cc1);
        logic evt;
        evt = 1'b0;
        case (mms)
            3'b000:  evt = ug;
            3'b010:  evt = uev;
            3'b011:  evt = cc1;
            default: evt = 1'b0;
        endcase
        return evt;
    endfunction

    // Channels beyond the implemented count read as a constant-low level.
    function automatic logic sel_level(input logic [2:0] mms, input logic cen,
                                       input logic [CH_NUM-1:0] ocref);
        logic lvl;
        lvl = 1'b0;
        if (mms == 3'b001) begin
            lvl = cen;
        end else if (mms[2]) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (i < 4 && int'(mms[1:0]) == i) lvl = ocref[i];
            end
        end
        return lvl;
    endfunction

    always_comb begin
        mms_chg    = (bus.mms_i != mms_q);
        level_mode = !is_pulse(mms_q);
        pulse_evt  = !mms_chg && is_pulse(bus.mms_i) &&
                     sel_pulse(bus.mms_i, bus.ug_i, bus.uev_i, bus.cc1_evt_i);
    end

    always_comb begin
        state_next = state;
`ifdef GPT_TRGO_STRETCH_EN
        cnt_next   = cnt;
`endif
        if (mms_chg || level_mode) begin
            state_next = IDLE;
`ifdef GPT_TRGO_STRETCH_EN
            cnt_next   = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_evt) begin
                        state_next = ACTIVE;
`ifdef GPT_TRGO_STRETCH_EN
                        cnt_next   = bus.pw_i;
`endif
                    end
                end
                ACTIVE: begin
`ifdef GPT_TRGO_STRETCH_EN
                    // A fresh event beats the terminal count so the output never gaps.
                    if (pulse_evt) begin
                        cnt_next = bus.pw_i;
                    end else if (cnt == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
`else
                    if (!pulse_evt) state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        if (mms_chg) begin
            pre = 1'b0;
        end else if (level_mode) begin
            pre = lvl_q;
        end else begin
            pre = (state == ACTIVE);
        end
        trgo_next = bus.msm_i ? dly_q : pre;
    end

    // Level sample follows the incoming selection; a source change is masked by mms_chg.
    always_ff @(posedge clk_i) begin
        lvl_q <= sel_level(bus.mms_i, bus.cen_i, bus.ocref_i);
    end

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            state   <= IDLE;
            mms_q   <= 3'b000;
            dly_q   <= 1'b0;
            trgo    <= 1'b0;
            trg_evt <= 1'b0;
`ifdef GPT_TRGO_STRETCH_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_next;
            mms_q   <= bus.mms_i;
            dly_q   <= pre;
            trgo    <= trgo_next;
            trg_evt <= trgo_next & ~trgo;
`ifdef GPT_TRGO_STRETCH_EN
            cnt     <= cnt_next;
`endif
        end
    end

    assign bus.trgo_o    = trgo;
    assign bus.trg_evt_o = trg_evt;

endmodule

// File: tb/tb_trgo_generator.sv
// Directed bench for trgo_generator: expected outputs are queued per edge and checked 1 ns later.
module tb_trgo_generator;

`ifdef GPT_TRGO_STRETCH_EN
    localparam bit STR = 1'b1;
`else
    localparam bit STR = 1'b0;
`endif

    logic clk = 1'b0;
    logic aresetn;

    always #5 clk = ~clk;

    trgo_if #(.CH_PAIRS_NUM(2)) bus_a ();
    trgo_if #(.CH_PAIRS_NUM(1)) bus_b ();

    assign bus_b.mms_i     = bus_a.mms_i;
    assign bus_b.ug_i      = bus_a.ug_i;
    assign bus_b.cen_i     = bus_a.cen_i;
    assign bus_b.uev_i     = bus_a.uev_i;
    assign bus_b.cc1_evt_i = bus_a.cc1_evt_i;
    assign bus_b.ocref_i   = bus_a.ocref_i[1:0];
    assign bus_b.msm_i     = bus_a.msm_i;
    assign bus_b.pw_i      = bus_a.pw_i;

    trgo_generator #(.CH_PAIRS_NUM(2)) dut (
        .clk_i     (clk),
        .aresetn_i (aresetn),
        .bus       (bus_a)
    );

    trgo_generator #(.CH_PAIRS_NUM(1)) dut_small (
        .clk_i     (clk),
        .aresetn_i (aresetn),
        .bus       (bus_b)
    );

    typedef struct {
        logic  t;
        logic  e;
        bit    c2;
        logic  t2;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input logic [1:0] te, input bit c2, input logic t2, input string tag);
        exp_t x;
        x.t = te[1]; x.e = te[0]; x.c2 = c2; x.t2 = t2; x.tag = tag;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        checks++;
        assert (bus_a.trgo_o === x.t) else begin
            errors++;
            $error("FAIL %s trgo_o got %b want %b", x.tag, bus_a.trgo_o, x.t);
        end
        checks++;
        assert (bus_a.trg_evt_o === x.e) else begin
            errors++;
            $error("FAIL %s trg_evt_o got %b want %b", x.tag, bus_a.trg_evt_o, x.e);
        end
        if (x.c2) begin
            checks++;
            assert (bus_b.trgo_o === x.t2) else begin
                errors++;
                $error("FAIL %s small trgo_o got %b want %b", x.tag, bus_b.trgo_o, x.t2);
            end
        end
    endtask

    task automatic tick(input logic [1:0] te, input string tag);
        chk(te, 1'b0, 1'b0, tag);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input forced high
        aresetn           = 1'b0;
        bus_a.mms_i       = 3'b111;
        bus_a.ug_i        = 1'b1;
        bus_a.cen_i       = 1'b1;
        bus_a.uev_i       = 1'b1;
        bus_a.cc1_evt_i   = 1'b1;
        bus_a.ocref_i     = 4'b1111;
        bus_a.msm_i       = 1'b1;
        bus_a.pw_i        = 4'd15;
        repeat (3) tick(2'b00, "reset");
        aresetn = 1'b1;
        tick(2'b00, "reset_release");

        // Update pulse, pw = 3
        bus_a.mms_i = 3'b010; bus_a.ug_i = 1'b0; bus_a.cen_i = 1'b0; bus_a.uev_i = 1'b0;
        bus_a.cc1_evt_i = 1'b0; bus_a.ocref_i = 4'b0000; bus_a.msm_i = 1'b0; bus_a.pw_i = 4'd3;
        settle(4);
        tick(2'b00, "upd_idle");
        bus_a.uev_i = 1'b1;
        tick(2'b00, "upd_e10");
        bus_a.uev_i = 1'b0;
        bus_a.pw_i  = 4'd9;
        for (int i = 1; i <= 6; i++) begin
            tick({(i <= (STR ? 4 : 1)) ? 1'b1 : 1'b0, (i == 1) ? 1'b1 : 1'b0}, "upd_pulse");
        end

        // Retrigger, pw = 2, events at edges 10 and 12
        bus_a.pw_i = 4'd2;
        settle(2);
        bus_a.uev_i = 1'b1;
        tick(2'b00, "rtg_e10");
        bus_a.uev_i = 1'b0;
        tick(2'b11, "rtg_e11");
        bus_a.uev_i = 1'b1;
        tick(STR ? 2'b10 : 2'b00, "rtg_e12");
        bus_a.uev_i = 1'b0;
        tick(STR ? 2'b10 : 2'b11, "rtg_e13");
        tick(STR ? 2'b10 : 2'b00, "rtg_e14");
        tick(STR ? 2'b10 : 2'b00, "rtg_e15");
        tick(2'b00, "rtg_e16");

        // MSM delay with OC2REF level
        bus_a.mms_i = 3'b101; bus_a.msm_i = 1'b1;
        settle(4);
        bus_a.ocref_i = 4'b0010;
        tick(2'b00, "msm_e20");
        tick(2'b00, "msm_e21");
        tick(2'b11, "msm_e22");
        tick(2'b10, "msm_e23");
        tick(2'b10, "msm_e24");
        bus_a.ocref_i = 4'b0000;
        tick(2'b10, "msm_e25");
        tick(2'b10, "msm_e26");
        tick(2'b00, "msm_e27");
        tick(2'b00, "msm_e28");

        // OC3REF: valid on the 4-channel unit, out of range on the 2-channel unit
        bus_a.mms_i = 3'b110; bus_a.msm_i = 1'b0; bus_a.ocref_i = 4'b0111;
        settle(3);
        for (int i = 0; i < 4; i++) chk(2'b10, 1'b1, 1'b0, "oc3_range");
        bus_a.ocref_i = 4'b1011;
        settle(3);
        for (int i = 0; i < 2; i++) chk(2'b00, 1'b1, 1'b0, "oc3_low");

        // Source switch mid-pulse: compare pulse then counter-enable level
        bus_a.mms_i = 3'b011; bus_a.pw_i = 4'd7; bus_a.cen_i = 1'b1; bus_a.ocref_i = 4'b0000;
        settle(3);
        bus_a.cc1_evt_i = 1'b1;
        tick(2'b00, "sw_e5");
        bus_a.cc1_evt_i = 1'b0;
        tick(2'b11, "sw_e6");
        tick(STR ? 2'b10 : 2'b00, "sw_e7");
        bus_a.mms_i = 3'b001;
        tick(2'b00, "sw_e8");
        tick(2'b11, "sw_e9");
        tick(2'b10, "sw_e10");

        // Reset in the middle of a stretched pulse
        bus_a.mms_i = 3'b010; bus_a.pw_i = 4'd15; bus_a.cen_i = 1'b0;
        settle(3);
        bus_a.uev_i = 1'b1;
        tick(2'b00, "rstmid_evt");
        bus_a.uev_i = 1'b0;
        tick(2'b11, "rstmid_rise");
        tick(STR ? 2'b10 : 2'b00, "rstmid_high");
        aresetn = 1'b0;
        tick(2'b00, "rstmid_cut");
        aresetn = 1'b1;
        tick(2'b00, "rstmid_after");
        tick(2'b00, "rstmid_after2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
